// File: rtl/sub_arb_pkg.sv
// sub_arb_pkg: shared types for the round-robin subtract arbiter.
//   sub_state_t - arbiter FSM state (IDLE, EXEC, RESP)
//   sub_flags_t - packed datapath flags {neg, zr, cry, of}
package sub_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sub_state_t;

  typedef struct packed {
    logic neg;
    logic zr;
    logic cry;
    logic of;
  } sub_flags_t;

  // Reset value of the round-robin pointer: the last requester, so the
  // search starts at requester 0.
  function automatic int rr_reset_ptr(input int num_req);
    return num_req - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   i_req  : request vector
//   i_last : index of the previous winner
//   o_oh   : one-hot winner (zero when no request)
//   o_idx  : winner index (zero when no request)
// Search starts at (i_last+1) mod NUM_REQ and wraps upward.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_oh,
  output logic [IW-1:0]      o_idx
);

  logic w_found;
  int   w_j;

  always_comb begin
    o_oh    = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_j = (int'(i_last) + off) % NUM_REQ;
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_oh[w_j]  = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/substractor_nbits.sv
// substractor_nbits: combinational N-bit subtractor with flags.
//   i_a, i_b : operands (diff = i_a - i_b, modulo 2^N)
//   o_diff   : difference
//   o_neg    : diff[N-1]
//   o_zr     : diff == 0
//   o_cry    : borrow out (unsigned i_a < i_b)
//   o_of     : signed two's-complement overflow
module substractor_nbits #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_neg,
  output logic         o_zr,
  output logic         o_cry,
  output logic         o_of
);

  logic [N:0] w_ext;

  // One extra bit catches the borrow out of the MSB.
  assign w_ext  = {1'b0, i_a} - {1'b0, i_b};
  assign o_diff = w_ext[N-1:0];
  assign o_cry  = w_ext[N];
  assign o_neg  = w_ext[N-1];
  assign o_zr   = (w_ext[N-1:0] == '0);
  // Overflow only when operand signs differ and the result sign flips
  // away from the minuend.
  assign o_of   = (i_a[N-1] != i_b[N-1]) && (w_ext[N-1] != i_a[N-1]);

endmodule

// File: rtl/sub_arbiter.sv
// sub_arbiter: round-robin arbiter in front of a shared N-bit subtractor.
// A requester's a/b operands are captured on grant, subtracted in EXEC,
// and the registered result/flags are held in RESP until accepted.
//   clk, rst          : clock, synchronous active-high reset
//   req               : per-requester level request
//   a_in, b_in        : packed operands, requester i at [i*N +: N]
//   gnt               : one-cycle one-hot "operands captured" pulse
//   result, *_flag    : registered difference and flags
//   rsp_id            : owner of the current response
//   rsp_valid/ready   : response handshake
//   busy              : high whenever the FSM is not IDLE
//   op_count          : accepted-response counter, saturating 16 bit
//                       (present only with SUB_ARB_STATS_EN defined)
module sub_arbiter
  import sub_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*N-1:0]       a_in,
  input  logic [NUM_REQ*N-1:0]       b_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [N-1:0]               result,
  output logic                       neg_flag,
  output logic                       zr_flag,
  output logic                       cry_flag,
  output logic                       of_flag,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
`ifdef SUB_ARB_STATS_EN
  output logic [15:0]                op_count,
`endif
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);

  sub_state_t           r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [N-1:0]         r_a, r_b, r_result;
  sub_flags_t           r_flags, w_flags;
  logic [IW-1:0]        r_own, r_rsp_id, r_last;
  logic                 r_rsp_valid;

  logic [NUM_REQ-1:0]   w_win_oh;
  logic [IW-1:0]        w_win_idx;
  logic [N-1:0]         w_a_sel, w_b_sel, w_diff;
  logic                 w_capture, w_exec, w_accept, w_busy;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_oh   (w_win_oh),
    .o_idx  (w_win_idx)
  );

  // Operand mux for the winning requester.
  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_idx == IW'(i)) begin
        w_a_sel = a_in[i*N +: N];
        w_b_sel = b_in[i*N +: N];
      end
    end
  end

  substractor_nbits #(.N(N)) u_sub (
    .i_a    (r_a),
    .i_b    (r_b),
    .o_diff (w_diff),
    .o_neg  (w_flags.neg),
    .o_zr   (w_flags.zr),
    .o_cry  (w_flags.cry),
    .o_of   (w_flags.of)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_exec      = 1'b0;
    w_accept    = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (|req) begin
          w_capture   = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_own       <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_last      <= IW'(rr_reset_ptr(NUM_REQ));
    end else begin
      r_gnt <= w_capture ? w_win_oh : '0;
      if (w_capture) begin
        r_a   <= w_a_sel;
        r_b   <= w_b_sel;
        r_own <= w_win_idx;
      end
      if (w_exec) begin
        r_result    <= w_diff;
        r_flags     <= w_flags;
        r_rsp_id    <= r_own;
        r_rsp_valid <= 1'b1;
      end
      // Pointer advances only on acceptance, so an aborted op does not
      // cost its owner a turn.
      if (w_accept) begin
        r_rsp_valid <= 1'b0;
        r_last      <= r_rsp_id;
      end
    end
  end

`ifdef SUB_ARB_STATS_EN
  logic [15:0] r_op_count;
  always_ff @(posedge clk) begin
    if (rst)
      r_op_count <= '0;
    else if (w_accept && (r_op_count != 16'hFFFF))
      r_op_count <= r_op_count + 16'd1;
  end
  assign op_count = r_op_count;
`endif

  assign gnt       = r_gnt;
  assign result    = r_result;
  assign neg_flag  = r_flags.neg;
  assign zr_flag   = r_flags.zr;
  assign cry_flag  = r_flags.cry;
  assign of_flag   = r_flags.of;
  assign rsp_id    = r_rsp_id;
  assign rsp_valid = r_rsp_valid;
  assign busy      = w_busy;

endmodule

// File: doc/sub_arbiter.md
SUB_ARBITER -- requirements
Module: sub_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand/result width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, giving the requester count; legal range 2..8.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  in  NUM_REQ  per-requester request, level.
REQ-006 SHALL have port a_in  in  NUM_REQ*N  minuends, requester i at bits [i*N +: N].
REQ-007 SHALL have port b_in  in  NUM_REQ*N  subtrahends, same packing.
REQ-008 SHALL have port gnt  out  NUM_REQ  one-hot, one-cycle pulse meaning "operands captured".
REQ-009 SHALL have port result  out  N  registered a minus b.
REQ-010 SHALL have port neg_flag, zr_flag, cry_flag, of_flag  out  1 each  registered datapath flags.
REQ-011 SHALL have port rsp_id  out  clog2(NUM_REQ)  index of the requester owning the response.
REQ-012 SHALL have port rsp_valid  out  1  response valid; rsp_ready  in  1  response accepted.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-015 In IDLE with req nonzero, SHALL pick the first set req bit searching upward from (last_winner+1) mod NUM_REQ, capture its a/b into operand registers, set gnt for that bit on the next cycle, and go to EXEC.
REQ-016 In IDLE with req zero, SHALL stay in IDLE with gnt all-zero.
REQ-017 In EXEC, SHALL register the subtractor result and all four flags, set rsp_valid, and go to RESP.
REQ-018 In RESP, SHALL hold result, flags, rsp_id and rsp_valid stable until a clock edge with rsp_ready high, then clear rsp_valid, set last_winner to rsp_id, and go to IDLE.
REQ-019 Latency SHALL be fixed: req sampled at edge k, gnt high in cycle k+1, rsp_valid high from cycle k+2.
REQ-020 Requests SHALL be ignored outside IDLE; a requester SHALL hold req and operands until its gnt pulse, and a req dropped before grant is a withdrawal with no response.
REQ-021 gnt SHALL be all-zero except for the single pulse cycle; at most one bit set.
REQ-022 Flags SHALL be the subtractor's flags for the captured operands, unmodified; zr_flag=1 if and only if result==0; neg_flag=result[N-1].
REQ-023 rsp_ready high while rsp_valid low SHALL have no effect.

Reset
REQ-024 On rst, SHALL force state IDLE, gnt=0, rsp_valid=0, result=0, all flags=0, rsp_id=0, busy=0, and last_winner=NUM_REQ-1, so requester 0 has first priority.
REQ-025 rst in EXEC or RESP SHALL abort the operation with no response; rst SHALL override all other inputs.

Configuration
REQ-026 With SUB_ARB_STATS_EN defined, SHALL add output op_count, 16 bits: reset 0, +1 on each accepted response (rsp_valid and rsp_ready), saturating at 0xFFFF.
REQ-027 Without SUB_ARB_STATS_EN, the op_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package sub_arb_pkg SHALL hold the FSM state enum (IDLE, EXEC, RESP) and a packed flags struct (neg, zr, cry, of).
REQ-029 The round-robin pick SHALL be one sub-module, rr_pick (inputs req and last_winner; outputs one-hot winner and index), which is purely combinational.
REQ-030 The datapath SHALL be one instance of the team's N-bit subtractor, substractor_nbits, fed from the operand registers.

Verification
REQ-031 Reset, then req=0001 with a0=5, b0=3 and rsp_ready held high: gnt=0001 in cycle k+1; rsp_valid in k+2 with result=2, zr=0, neg=0, rsp_id=0.
REQ-032 req0 only with a0=3, b0=5: result=4'hE, neg_flag=1, zr_flag=0.
REQ-033 req0 only with a0=5, b0=5: result=0, zr_flag=1.
REQ-034 req=1111 held with rsp_ready high: grants in order 0,1,2,3,0; no requester is granted twice before all others.
REQ-035 rsp_ready low for 5 cycles in RESP: rsp_valid, result and rsp_id stay stable, gnt stays 0, and req changes are ignored.
REQ-036 rst asserted in EXEC: next cycle is IDLE, rsp_valid=0, and there is no response; with SUB_ARB_STATS_EN defined, op_count=0 after reset and counts only accepted responses.
